// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// acknowledge levels and the R/W bit meaning.
package i2c_pkg;

    localparam int BYTE_W = 8;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_target_if.sv
// Bus pins plus parallel register port of the I2C target. The target
// attaches through the slave modport; the bus/register side uses master.
interface i2c_target_if;
    import i2c_pkg::*;

    logic              scl_i;
    logic              sda_i;
    logic              sda_oe;
    logic [BYTE_W-1:0] reg_addr;
    logic [BYTE_W-1:0] reg_wdata;
    logic [BYTE_W-1:0] reg_rdata;
    logic              reg_we;
    logic              reg_re;
    logic              busy;
    logic              addressed;

    modport slave (
        input  scl_i, sda_i, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, addressed
    );

    modport master (
        output scl_i, sda_i, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, addressed
    );

endinterface

// File: rtl/i2c_line_filter.sv
// One bus line: 2-flop synchroniser, FILTER_LEN-sample glitch filter and
// single-cycle rise/fall pulses on the filtered level.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pin,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic [3:0] cnt;
    logic       filt_q;

    // A new level is accepted once it has been seen FILTER_LEN cycles running.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync   <= 2'b11;
            cnt    <= '0;
            filt   <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            sync   <= {sync[0], pin};
            filt_q <= filt;
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == 4'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign rise = filt & ~filt_q;
    assign fall = ~filt & filt_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target translating bus transfers into register read/write strobes.
// Oversamples SCL/SDA in clk_sys; sub-address byte loads the pointer.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h39,
    parameter int         FILTER_LEN  = 3
) (
    input logic        clk_sys,
    input logic        reset,
    i2c_target_if.slave bus
);

    localparam int SCL = 0;
    localparam int SDA = 1;

    logic [1:0] pins, filt, rise, fall;

    assign pins = {bus.sda_i, bus.scl_i};

    for (genvar i = 0; i < 2; i++) begin : g_line
        i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk_sys (clk_sys),
            .reset   (reset),
            .pin     (pins[i]),
            .filt    (filt[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    logic sda_f, scl_rise, scl_fall, start, stop;
    assign sda_f    = filt[SDA];
    assign scl_rise = rise[SCL];
    assign scl_fall = fall[SCL];
    assign start    = fall[SDA] & filt[SCL];
    assign stop     = rise[SDA] & filt[SCL];

    i2c_tgt_state_t    state, state_n;
    logic [3:0]        bit_cnt, cnt_n;
    logic [BYTE_W-1:0] shreg, sh_n, ptr, ptr_n, tx, tx_n, wdata, wdata_n;
    logic              rw, rw_n, oe_q, oe_n, adr_q, adr_n;
    logic              we_q, we_n, re_q, re_n, re_d;
    logic [BYTE_W-1:0] new_byte;

    assign new_byte = {shreg[6:0], sda_f};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            tx      <= '0;
            wdata   <= '0;
            rw      <= RW_WRITE;
            oe_q    <= 1'b0;
            adr_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            re_d    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            shreg   <= sh_n;
            ptr     <= ptr_n;
            tx      <= tx_n;
            wdata   <= wdata_n;
            rw      <= rw_n;
            oe_q    <= oe_n;
            adr_q   <= adr_n;
            we_q    <= we_n;
            re_q    <= re_n;
            re_d    <= re_q;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        ptr_n   = ptr;
        tx_n    = tx;
        wdata_n = wdata;
        rw_n    = rw;
        oe_n    = oe_q;
        adr_n   = adr_q;
        we_n    = 1'b0;
        re_n    = 1'b0;

        // Pointer advances in the cycle after the write strobe so reg_addr
        // is stable for the whole strobe; read data lands one cycle after reg_re.
        if (we_q) ptr_n = ptr + 8'd1;
        if (re_d) tx_n = bus.reg_rdata;

        if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            adr_n   = 1'b0;
        end else if (start) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
            adr_n   = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    sh_n  = new_byte;
                    cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        cnt_n = '0;
                        if (new_byte[7:1] == TARGET_ADDR) begin
                            state_n = ADDR_ACK;
                            rw_n    = new_byte[0];
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise && rw == RW_READ) re_n = 1'b1;
                    // First fall starts the ACK, second fall ends it.
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_n  = 1'b1;
                            adr_n = 1'b1;
                        end else if (rw == RW_READ) begin
                            state_n = RDATA;
                            oe_n    = ~tx[7];
                            tx_n    = {tx[6:0], 1'b0};
                            cnt_n   = 4'd1;
                        end else begin
                            state_n = SUB;
                            oe_n    = 1'b0;
                        end
                    end
                end
                SUB: if (scl_rise) begin
                    sh_n  = new_byte;
                    cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        ptr_n   = new_byte;
                        cnt_n   = '0;
                        state_n = SUB_ACK;
                    end
                end
                SUB_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_n = 1'b1;
                    end else begin
                        oe_n    = 1'b0;
                        state_n = WDATA;
                    end
                end
                WDATA: if (scl_rise) begin
                    sh_n  = new_byte;
                    cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        we_n    = 1'b1;
                        wdata_n = new_byte;
                        cnt_n   = '0;
                        state_n = WDATA_ACK;
                    end
                end
                RDATA: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        oe_n    = 1'b0;
                        ptr_n   = ptr + 8'd1;
                        cnt_n   = '0;
                        state_n = RDATA_ACK;
                    end else begin
                        oe_n  = ~tx[7];
                        tx_n  = {tx[6:0], 1'b0};
                        cnt_n = bit_cnt + 4'd1;
                    end
                end
                RDATA_ACK: if (scl_rise) begin
                    if (sda_f == ACK) begin
                        re_n    = 1'b1;
                        cnt_n   = '0;
                        state_n = RDATA;
                    end else begin
                        state_n = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe    = oe_q;
    assign bus.reg_addr  = ptr;
    assign bus.reg_wdata = wdata;
    assign bus.reg_we    = we_q;
    assign bus.reg_re    = re_q;
    assign bus.busy      = (state != IDLE);
    assign bus.addressed = adr_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller drives the bus,
// a register model returns addr^0x5A, and a monitor records strobes.
module tb_i2c_target;

    localparam int Q = 8;
    localparam int H = 16;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk_sys = ~clk_sys;

    i2c_target_if bus();

    assign bus.scl_i     = scl_drv;
    assign bus.sda_i     = sda_drv & ~bus.sda_oe;
    assign bus.reg_rdata = bus.reg_addr ^ 8'h5A;

    i2c_target #(.TARGET_ADDR(7'h39), .FILTER_LEN(3)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    logic [7:0] we_addr_q[$];
    logic [7:0] we_data_q[$];
    logic [7:0] re_addr_q[$];
    logic       oe_seen;
    logic       adr_seen;

    always @(negedge clk_sys) begin
        if (bus.reg_we) begin
            we_addr_q.push_back(bus.reg_addr);
            we_data_q.push_back(bus.reg_wdata);
        end
        if (bus.reg_re) re_addr_q.push_back(bus.reg_addr);
        if (bus.sda_oe) oe_seen <= 1'b1;
        if (bus.addressed) adr_seen <= 1'b1;
    end

    typedef struct {
        logic [7:0]      addr_byte;
        logic [7:0]      sub;
        logic [2:0][7:0] data;
        int              nd;
        logic            exp_ack;
        int              exp_we;
        logic [7:0]      exp_ptr;
    } wr_vec_t;

    function automatic wr_vec_t mk(input logic [7:0] a, input logic [7:0] s,
                                   input logic [7:0] d0, input logic [7:0] d1,
                                   input logic [7:0] d2, input int nd,
                                   input logic ea, input int ew, input logic [7:0] ep);
        wr_vec_t v;
        v.addr_byte = a;
        v.sub       = s;
        v.data[0]   = d0;
        v.data[1]   = d1;
        v.data[2]   = d2;
        v.nd        = nd;
        v.exp_ack   = ea;
        v.exp_we    = ew;
        v.exp_ptr   = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic clear_mon();
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
        oe_seen  = 1'b0;
        adr_seen = 1'b0;
    endtask

    task automatic i2c_start();
        cyc(Q);
        sda_drv = 1'b1;
        cyc(Q);
        scl_drv = 1'b1;
        cyc(H);
        sda_drv = 1'b0;
        cyc(H);
        scl_drv = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(Q);
        sda_drv = 1'b0;
        cyc(Q);
        scl_drv = 1'b1;
        cyc(H);
        sda_drv = 1'b1;
        cyc(H);
    endtask

    // glitch=1 pulses SCL low for FILTER_LEN-1 cycles in the high phase
    task automatic send_bit(input logic b, input logic glitch, output logic s);
        cyc(Q);
        sda_drv = b;
        cyc(Q);
        scl_drv = 1'b1;
        cyc(H / 2);
        s = bus.sda_i;
        if (glitch) begin
            scl_drv = 1'b0;
            cyc(2);
            scl_drv = 1'b1;
        end
        cyc(H / 2);
        scl_drv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit, s);
        send_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic ack_in, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        send_bit(ack_in, 1'b0, s);
    endtask

    wr_vec_t    vecs[5];
    logic       ack;
    int         nack_cnt;
    logic [7:0] rd0, rd1;

    initial begin
        vecs[0] = mk(8'h72, 8'h41, 8'h10, 8'h00, 8'h00, 1, 1'b1, 1, 8'h42);
        vecs[1] = mk(8'h72, 8'hFE, 8'hAA, 8'hBB, 8'hCC, 3, 1'b1, 3, 8'h01);
        vecs[2] = mk(8'h72, 8'h05, 8'h33, 8'h44, 8'h00, 2, 1'b1, 2, 8'h07);
        vecs[3] = mk(8'h70, 8'h41, 8'h10, 8'h00, 8'h00, 1, 1'b0, 0, 8'h07);
        vecs[4] = mk(8'hF2, 8'h41, 8'h10, 8'h00, 8'h00, 1, 1'b0, 0, 8'h07);

        cyc(5);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_reg_addr", bus.reg_addr, 8'h00);
        chk("rst_reg_we", bus.reg_we, 0);
        chk("rst_reg_re", bus.reg_re, 0);
        chk("rst_addressed", bus.addressed, 0);
        reset = 1'b0;
        cyc(10);

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            nack_cnt = 0;
            i2c_start();
            write_byte(vecs[v].addr_byte, -1, ack);
            if (ack != 1'b0) nack_cnt++;
            write_byte(vecs[v].sub, -1, ack);
            if (ack != 1'b0) nack_cnt++;
            for (int d = 0; d < vecs[v].nd; d++) begin
                write_byte(vecs[v].data[d], -1, ack);
                if (ack != 1'b0) nack_cnt++;
            end
            chk($sformatf("v%0d_busy_before_stop", v), bus.busy, vecs[v].exp_ack);
            i2c_stop();
            chk($sformatf("v%0d_nacked_bytes", v), nack_cnt, vecs[v].exp_ack ? 0 : vecs[v].nd + 2);
            chk($sformatf("v%0d_we_count", v), we_addr_q.size(), vecs[v].exp_we);
            for (int i = 0; i < vecs[v].exp_we && i < we_addr_q.size(); i++) begin
                chk($sformatf("v%0d_we%0d_addr", v, i), we_addr_q[i], 8'(vecs[v].sub + i));
                chk($sformatf("v%0d_we%0d_data", v, i), we_data_q[i], vecs[v].data[i]);
            end
            chk($sformatf("v%0d_re_count", v), re_addr_q.size(), 0);
            chk($sformatf("v%0d_oe_seen", v), oe_seen, vecs[v].exp_ack);
            chk($sformatf("v%0d_addressed_seen", v), adr_seen, vecs[v].exp_ack);
            chk($sformatf("v%0d_ptr", v), bus.reg_addr, vecs[v].exp_ptr);
            chk($sformatf("v%0d_busy_after_stop", v), bus.busy, 0);
            chk($sformatf("v%0d_addressed_after_stop", v), bus.addressed, 0);
        end

        // Sub-address write, repeated START, two-byte read with final NACK
        clear_mon();
        nack_cnt = 0;
        i2c_start();
        write_byte(8'h72, -1, ack);
        if (ack != 1'b0) nack_cnt++;
        write_byte(8'h20, -1, ack);
        if (ack != 1'b0) nack_cnt++;
        i2c_start();
        write_byte(8'h73, -1, ack);
        if (ack != 1'b0) nack_cnt++;
        read_byte(1'b0, rd0);
        read_byte(1'b1, rd1);
        chk("rd_nacked_bytes", nack_cnt, 0);
        chk("rd_byte0", rd0, 8'h7A);
        chk("rd_byte1", rd1, 8'h7B);
        chk("rd_re_count", re_addr_q.size(), 2);
        if (re_addr_q.size() == 2) begin
            chk("rd_re0_addr", re_addr_q[0], 8'h20);
            chk("rd_re1_addr", re_addr_q[1], 8'h21);
        end
        chk("rd_we_count", we_addr_q.size(), 0);
        cyc(3 * H);
        chk("rd_wait_stop_busy", bus.busy, 1);
        chk("rd_wait_stop_oe", bus.sda_oe, 0);
        i2c_stop();
        chk("rd_busy_after_stop", bus.busy, 0);
        chk("rd_ptr", bus.reg_addr, 8'h22);

        // Short SCL glitch in the middle of a data byte
        clear_mon();
        nack_cnt = 0;
        i2c_start();
        write_byte(8'h72, -1, ack);
        if (ack != 1'b0) nack_cnt++;
        write_byte(8'h50, -1, ack);
        if (ack != 1'b0) nack_cnt++;
        write_byte(8'h3C, 4, ack);
        if (ack != 1'b0) nack_cnt++;
        write_byte(8'h5A, -1, ack);
        if (ack != 1'b0) nack_cnt++;
        i2c_stop();
        chk("gl_nacked_bytes", nack_cnt, 0);
        chk("gl_we_count", we_addr_q.size(), 2);
        if (we_addr_q.size() == 2) begin
            chk("gl_we0_addr", we_addr_q[0], 8'h50);
            chk("gl_we0_data", we_data_q[0], 8'h3C);
            chk("gl_we1_addr", we_addr_q[1], 8'h51);
            chk("gl_we1_data", we_data_q[1], 8'h5A);
        end
        chk("gl_ptr", bus.reg_addr, 8'h52);

        // Reset while the target pulls SDA low for read bit7 (0x7A)
        clear_mon();
        i2c_start();
        write_byte(8'h72, -1, ack);
        write_byte(8'h20, -1, ack);
        i2c_start();
        write_byte(8'h73, -1, ack);
        for (int i = 0; i < 40 && !bus.sda_oe; i++) cyc(1);
        chk("rst_mid_driving", bus.sda_oe, 1);
        reset = 1'b1;
        cyc(1);
        chk("rst_mid_sda_oe", bus.sda_oe, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_ptr", bus.reg_addr, 8'h00);
        chk("rst_mid_addressed", bus.addressed, 0);
        reset = 1'b0;
        sda_drv = 1'b1;
        cyc(Q);
        scl_drv = 1'b1;
        cyc(2 * H);
        chk("rst_mid_idle_after", bus.busy, 0);

        clear_mon();
        nack_cnt = 0;
        i2c_start();
        write_byte(8'h72, -1, ack);
        if (ack != 1'b0) nack_cnt++;
        write_byte(8'h10, -1, ack);
        if (ack != 1'b0) nack_cnt++;
        write_byte(8'h99, -1, ack);
        if (ack != 1'b0) nack_cnt++;
        i2c_stop();
        chk("post_rst_nacked_bytes", nack_cnt, 0);
        chk("post_rst_we_count", we_addr_q.size(), 1);
        if (we_addr_q.size() == 1) begin
            chk("post_rst_we_addr", we_addr_q[0], 8'h10);
            chk("post_rst_we_data", we_data_q[0], 8'h99);
        end
        chk("post_rst_ptr", bus.reg_addr, 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) at the far end of the bus driven by our i2c_master.
- Default address 7'h39 matches the HDMI transmitter register bank, so the block serves as an in-FPGA stand-in for that device. It is also reusable as a generic register-mapped I2C target.
- Decodes START/STOP, address, sub-address and data bytes. Translates them into one-cycle register read/write strobes on a parallel register port.
- Runs in the clk_sys domain (24 MHz in arcade tops) and oversamples SCL/SDA. No clock stretching.

Parameters:
- TARGET_ADDR, 7'h39: 7-bit bus address answered.
- FILTER_LEN, 3: consecutive equal samples required before a filtered line changes (1..15).

Ports:
- clk_sys  in  1: system clock.
- reset  in  1: synchronous, active-high.
- scl_i  in  1: raw SCL pin level.
- sda_i  in  1: raw SDA pin level.
- sda_oe  out  1: 1 = pull SDA low, 0 = release.
- reg_addr  out  8: register pointer for the current access.
- reg_wdata  out  8: write data; valid while reg_we=1.
- reg_we  out  1: one-cycle write strobe.
- reg_re  out  1: one-cycle read request.
- reg_rdata  in  8: read data, sampled exactly 1 cycle after reg_re.
- busy  out  1: state != IDLE.
- addressed  out  1: high from our address ACK until the next START or STOP.

Behaviour:
- Reset: clock clk_sys; reset is synchronous, active-high. All outputs 0, pointer = 8'h00, state IDLE, filtered lines = 1. Reset mid-transfer releases sda_oe on the next cycle. No partial strobe is issued.
- Input path: 2-flop synchroniser, then glitch filter. Pin-to-filtered latency is 2+FILTER_LEN cycles. Edge detection runs on the filtered lines.
- START = filtered SDA falls while SCL=1. STOP = filtered SDA rises while SCL=1.
- Event priority in a single cycle: STOP > START > SCL rise/fall.
- STOP in any state: go to IDLE and release SDA.
- START (including repeated START) in any state: go to ADDR, clear bit count, release SDA. The pointer is kept.
- Data is sampled on SCL rise. sda_oe changes only on SCL fall, in the cycle after the filtered fall.
- States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE: ignore SCL; leave only on START.
- ADDR: shift 8 bits MSB-first. On the 8th rise:
  - address match: arm ACK.
  - mismatch: go to IDLE; no further drive or strobes.
- ADDR_ACK:
  - Drive sda_oe=1 from the fall after the 8th rise until the fall after the 9th rise.
  - R/W=0: go to SUB at the ACK-ending fall.
  - R/W=1: pulse reg_re (reg_addr = pointer) on the 9th rise and latch reg_rdata the next cycle. At the ACK-ending fall go to RDATA and drive bit7.
- SUB: 8 bits loaded into the pointer, then SUB_ACK, then WDATA.
- WDATA: after 8 bits, pulse reg_we for one cycle on the 8th rise (reg_addr = pointer, reg_wdata = byte), then WDATA_ACK. The pointer increments after the strobe, wrapping 8'hFF to 8'h00. Byte count is unlimited.
- RDATA:
  - Each fall drives sda_oe = ~bit, MSB first.
  - Release SDA on the 8th fall. The pointer increments on that fall (wraps).
  - RDATA_ACK samples the controller on the 9th rise:
    - SDA=0 (ACK): pulse reg_re at the new pointer, latch data, return to RDATA.
    - SDA=1 (NACK): go to WAIT_STOP, with SDA released.
- WAIT_STOP: ignore bits; exit only on START or STOP.
- Bus timing requirement: SCL high and low phases each ≥ 2·(FILTER_LEN+3) clk_sys cycles. At 24 MHz, 400 kHz gives 30 cycles, which is adequate.

Decomposition:
- Package i2c_pkg:
  - state enum (typedef i2c_tgt_state_t);
  - ACK=1'b0, NACK=1'b1;
  - RW_WRITE / RW_READ constants;
  - byte width 8.
- Sub-module i2c_line_filter: synchroniser + glitch filter + rise/fall pulses. Instantiated twice (SCL, SDA); parameter FILTER_LEN.
- Top: state machine, bit counter (0..8), shift register, pointer.

Test Plan:
- Write: START, 0x72, 0x41, 0x10, STOP -> ACK driven on all 3 bytes; exactly one reg_we with reg_addr=0x41, reg_wdata=0x10; pointer=0x42; busy low after STOP.
- Wrap: write sub 0xFE, data 0xAA, 0xBB, 0xCC -> reg_we at 0xFE, 0xFF, 0x00 with those data values; pointer=0x01.
- Read: write sub 0x20, repeated START 0x73, controller ACKs the first byte and NACKs the second (bench returns rdata = addr^0x5A) -> SDA carries 0x7A then 0x7B; reg_re at 0x20 and 0x21; WAIT_STOP until STOP; pointer=0x22.
- Mismatch: START, 0x70, 0x41, 0x10 -> sda_oe never asserted, no reg_we/reg_re, addressed=0.
- Glitch: SCL low pulse of FILTER_LEN-1 cycles mid-byte -> no extra bit shifted; the next byte still decodes correctly.
- Reset while driving a 0 data bit in RDATA -> sda_oe=0 the next cycle, busy=0, pointer=0. A subsequent full write transaction works.
